// File: rtl/sensor_noise_gen.sv
// Frame-synchronous pixel noise injector: salt-and-pepper, additive signed
// noise or fixed-pattern hot pixels, with a per-frame corrupted-sample count.
module sensor_noise_gen #(
  parameter int          DATA_WIDTH    = 8,
  parameter int          CHANNEL_NUM   = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          DEFECT_PERIOD = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        iv_noise_mode,
  input  logic [7:0]                        iv_density,
  input  logic [2:0]                        iv_amp,
  input  logic                              i_frame_reseed,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [23:0]                       ov_noise_cnt
);
  localparam int PW = DATA_WIDTH * CHANNEL_NUM;
  localparam int CW = (DEFECT_PERIOD > 1) ? $clog2(DEFECT_PERIOD) : 1;
  localparam logic [CW-1:0]         COL_LAST = CW'(DEFECT_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX  = '1;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int s);
    logic [31:0] t;
    t = {x, x} << s;
    return t[31:16];
  endfunction

  // Sum never leaves [-128, 2^DW-1+127], so sign bit and bit DW suffice.
  function automatic logic [DATA_WIDTH-1:0] sat_pix(input logic signed [DATA_WIDTH+1:0] v);
    if (v[DATA_WIDTH+1])   return '0;
    else if (v[DATA_WIDTH]) return PIX_MAX;
    else                    return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[24] ? 24'hFF_FFFF : s[23:0];
  endfunction

  function automatic logic [23:0] popcnt(input logic [CHANNEL_NUM-1:0] h);
    logic [23:0] n;
    n = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) n = n + 24'(h[i]);
    return n;
  endfunction

  // Returns {hit, corrupted sample} for one channel.
  function automatic logic [DATA_WIDTH:0] noise_chan(
    input logic [1:0]            mode,
    input logic [7:0]            dens,
    input logic [2:0]            amp,
    input logic                  defect,
    input logic [15:0]           r,
    input logic [DATA_WIDTH-1:0] din
  );
    logic signed [DATA_WIDTH+1:0] ofs;
    logic signed [DATA_WIDTH+1:0] sum;
    logic [DATA_WIDTH-1:0]        dout;
    logic                         hit;
    dout = din;
    hit  = 1'b0;
    ofs  = {{(DATA_WIDTH + 2 - 8){r[15]}}, r[15:8]};
    ofs  = ofs >>> (3'd7 - amp);
    sum  = $signed({2'b00, din}) + ofs;
    case (mode)
      2'd1: if (r[7:0] < dens) begin
        hit  = 1'b1;
        dout = r[8] ? PIX_MAX : '0;
      end
      2'd2: begin
        dout = sat_pix(sum);
        hit  = (dout != din);
      end
      2'd3: begin
        if (defect) dout = PIX_MAX;
        hit = (dout != din);
      end
      default: ;
    endcase
    return {hit, dout};
  endfunction

  logic [15:0]            lfsr;
  logic [1:0]             mode_q;
  logic [7:0]             density_q;
  logic [2:0]             amp_q;
  logic [CW-1:0]          col_q;
  logic                   line_odd_q;
  logic [23:0]            cnt_q;
  logic                   fval_p1;
  logic                   lval_p1;
  logic [PW-1:0]          pix_p1;
  logic [23:0]            noise_cnt_p1;

  logic                   frame_start;
  logic                   frame_end;
  logic                   line_end;
  logic                   pix_vld;
  logic [1:0]             mode_e;
  logic [7:0]             density_e;
  logic [2:0]             amp_e;
  logic                   defect_loc;
  logic [PW-1:0]          pix_eff;
  logic [CHANNEL_NUM-1:0] hit;

  assign frame_start = i_fval & ~fval_p1;
  assign frame_end   = ~i_fval & fval_p1;
  assign line_end    = i_fval & ~i_lval & lval_p1;
  assign pix_vld     = i_fval & i_lval;

  // The frame-start cycle already sees the configuration being latched.
  assign mode_e     = frame_start ? iv_noise_mode : mode_q;
  assign density_e  = frame_start ? iv_density    : density_q;
  assign amp_e      = frame_start ? iv_amp        : amp_q;
  assign defect_loc = (col_q == COL_LAST) & line_odd_q & ~frame_start;

  // Stage p0: noise applied combinationally on the incoming sample
  always_comb begin
    pix_eff = iv_pix_data;
    hit     = '0;
    if (pix_vld) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        {hit[k], pix_eff[k*DATA_WIDTH +: DATA_WIDTH]} =
          noise_chan(mode_e, density_e, amp_e, defect_loc, rotl16(lfsr, (3 * k) % 16),
                     iv_pix_data[k*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr         <= LFSR_SEED;
      mode_q       <= '0;
      density_q    <= '0;
      amp_q        <= '0;
      col_q        <= '0;
      line_odd_q   <= 1'b0;
      cnt_q        <= '0;
      noise_cnt_p1 <= '0;
    end else begin
      if (frame_start) begin
        mode_q    <= iv_noise_mode;
        density_q <= iv_density;
        amp_q     <= iv_amp;
      end
      if (frame_start && i_frame_reseed) lfsr <= LFSR_SEED;
      else if (pix_vld)                  lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (!i_lval)     col_q <= '0;
      else if (i_fval) col_q <= (col_q == COL_LAST) ? '0 : col_q + CW'(1);
      if (frame_start)   line_odd_q <= 1'b0;
      else if (line_end) line_odd_q <= ~line_odd_q;
      if (frame_end) begin
        noise_cnt_p1 <= cnt_q;
        cnt_q        <= '0;
      end else if (pix_vld) begin
        cnt_q <= sat_add24(cnt_q, popcnt(hit));
      end
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_p1 <= 1'b0;
      lval_p1 <= 1'b0;
      pix_p1  <= '0;
    end else begin
      fval_p1 <= i_fval;
      lval_p1 <= i_lval;
      pix_p1  <= pix_eff;
    end
  end

  assign o_fval       = fval_p1;
  assign o_lval       = lval_p1;
  assign ov_pix_data  = pix_p1;
  assign ov_noise_cnt = noise_cnt_p1;
endmodule

// File: tb/tb_sensor_noise_gen.sv
// Directed bench for sensor_noise_gen: table of frame configurations checked
// against a cycle model, plus hand sequences for reset behaviour.
module tb_sensor_noise_gen;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        reset;
  logic [1:0]  iv_noise_mode;
  logic [7:0]  iv_density;
  logic [2:0]  iv_amp;
  logic        i_frame_reseed;
  logic        i_fval;
  logic        i_lval;
  logic [31:0] iv_pix_data;
  logic        o_fval;
  logic        o_lval;
  logic [31:0] ov_pix_data;
  logic [23:0] ov_noise_cnt;

  int          checks;
  int          errors;
  int          frame_idx;
  logic [15:0] m_lfsr;
  logic [7:0]  pix_ctr;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] dens;
    logic [2:0] amp;
    logic       reseed;
    logic [1:0] mid_mode;
    logic       cnst;
    logic [7:0] val;
    int         exp_cnt;
  } frame_vec_t;

  frame_vec_t vecs [12];

  sensor_noise_gen #(
    .DATA_WIDTH(8), .CHANNEL_NUM(4), .LFSR_SEED(16'hACE1), .DEFECT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .iv_noise_mode(iv_noise_mode), .iv_density(iv_density),
    .iv_amp(iv_amp), .i_frame_reseed(i_frame_reseed), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(iv_pix_data), .o_fval(o_fval), .o_lval(o_lval),
    .ov_pix_data(ov_pix_data), .ov_noise_cnt(ov_noise_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL frame%0d %s: got %h expected %h", frame_idx, name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Reference for one channel: returns {hit, expected sample}.
  function automatic logic [8:0] model_chan(input logic [1:0] mode, input logic [7:0] dens,
                                            input logic [2:0] amp, input int line, input int col,
                                            input int k, input logic [15:0] lf, input logic [7:0] din);
    logic [15:0] r;
    int n, v;
    for (int i = 0; i < 16; i++) r[(i + 3 * k) % 16] = lf[i];
    case (mode)
      2'd1: begin
        if (r[7:0] < dens) return {1'b1, (r[8] ? 8'hFF : 8'h00)};
        return {1'b0, din};
      end
      2'd2: begin
        n = int'(r[15:8]);
        if (n > 127) n = n - 256;
        v = int'(din) + (n >>> (7 - int'(amp)));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return {(v != int'(din)), v[7:0]};
      end
      2'd3: begin
        if ((col % 4 == 3) && (line % 2 == 1)) return {(din != 8'hFF), 8'hFF};
        return {1'b0, din};
      end
      default: return {1'b0, din};
    endcase
  endfunction

  function automatic logic [31:0] next_pix(input frame_vec_t v);
    logic [7:0] b;
    if (v.cnst) return {4{v.val}};
    b = pix_ctr;
    pix_ctr = pix_ctr + 8'd4;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic step(input logic fv, input logic lv, input logic [31:0] pix, input logic [31:0] exp_pix);
    i_fval      = fv;
    i_lval      = lv;
    iv_pix_data = pix;
    @(posedge clk);
    #1;
    check("o_fval", {31'd0, o_fval}, {31'd0, fv});
    check("o_lval", {31'd0, o_lval}, {31'd0, lv});
    check("ov_pix_data", ov_pix_data, exp_pix);
  endtask

  // One frame: start cycle, 4 lines of 8 valid cycles plus 2 blanking, then end.
  task automatic run_frame(input frame_vec_t v, input int idx);
    logic [31:0] pix, expp;
    logic [8:0]  r;
    int          cnt;
    cnt            = 0;
    frame_idx      = idx;
    iv_noise_mode  = v.mode;
    iv_density     = v.dens;
    iv_amp         = v.amp;
    i_frame_reseed = v.reseed;
    if (v.reseed) m_lfsr = SEED;
    pix = next_pix(v);
    step(1'b1, 1'b0, pix, pix);
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 8; c++) begin
        pix  = next_pix(v);
        expp = pix;
        for (int k = 0; k < 4; k++) begin
          r = model_chan(v.mode, v.dens, v.amp, l, c, k, m_lfsr, pix[k*8 +: 8]);
          expp[k*8 +: 8] = r[7:0];
          cnt = cnt + int'(r[8]);
        end
        step(1'b1, 1'b1, pix, expp);
        m_lfsr = lfsr_next(m_lfsr);
      end
      for (int b = 0; b < 2; b++) begin
        pix = next_pix(v);
        step(1'b1, 1'b0, pix, pix);
      end
      if (l == 0) iv_noise_mode = v.mid_mode;
    end
    pix = next_pix(v);
    step(1'b0, 1'b0, pix, pix);
    check("noise_cnt", {8'd0, ov_noise_cnt}, cnt);
    if (v.exp_cnt >= 0) check("noise_cnt_hand", {8'd0, ov_noise_cnt}, v.exp_cnt);
    pix = next_pix(v);
    step(1'b0, 1'b0, pix, pix);
    check("noise_cnt_hold", {8'd0, ov_noise_cnt}, cnt);
  endtask

  initial begin
    frame_vec_t fin;
    checks = 0;
    errors = 0;
    frame_idx = 0;
    pix_ctr = 8'd0;
    m_lfsr = SEED;
    //         mode   dens    amp   rsd   mid    cnst  val     cnt
    vecs[0]  = '{2'd0, 8'd0,   3'd0, 1'b0, 2'd0, 1'b0, 8'h00, 0};
    vecs[1]  = '{2'd0, 8'd0,   3'd0, 1'b0, 2'd0, 1'b0, 8'h00, 0};
    vecs[2]  = '{2'd1, 8'd0,   3'd0, 1'b1, 2'd1, 1'b0, 8'h00, 0};
    vecs[3]  = '{2'd1, 8'd255, 3'd0, 1'b1, 2'd1, 1'b0, 8'h00, -1};
    vecs[4]  = '{2'd1, 8'd255, 3'd0, 1'b1, 2'd1, 1'b0, 8'h00, -1};
    vecs[5]  = '{2'd2, 8'd0,   3'd7, 1'b0, 2'd2, 1'b1, 8'hFF, -1};
    vecs[6]  = '{2'd2, 8'd0,   3'd7, 1'b0, 2'd2, 1'b1, 8'h00, -1};
    vecs[7]  = '{2'd2, 8'd0,   3'd0, 1'b0, 2'd2, 1'b1, 8'h80, -1};
    vecs[8]  = '{2'd1, 8'd128, 3'd0, 1'b0, 2'd0, 1'b0, 8'h00, -1};
    vecs[9]  = '{2'd0, 8'd128, 3'd0, 1'b0, 2'd0, 1'b1, 8'h55, 0};
    vecs[10] = '{2'd2, 8'd0,   3'd4, 1'b1, 2'd2, 1'b0, 8'h00, -1};
    vecs[11] = '{2'd3, 8'd0,   3'd0, 1'b0, 2'd3, 1'b1, 8'h10, 16};

    reset = 1'b1;
    iv_noise_mode = 2'd0;
    iv_density = 8'd0;
    iv_amp = 3'd0;
    i_frame_reseed = 1'b0;
    i_fval = 1'b0;
    i_lval = 1'b0;
    iv_pix_data = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_fval", {31'd0, o_fval}, 32'd0);
    check("rst_o_lval", {31'd0, o_lval}, 32'd0);
    check("rst_pix", ov_pix_data, 32'd0);
    check("rst_cnt", {8'd0, ov_noise_cnt}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_frame(vecs[i], i);

    // Reset in the middle of a line: outputs drop before the next clock edge.
    frame_idx = 99;
    iv_noise_mode = 2'd3;
    i_frame_reseed = 1'b0;
    step(1'b1, 1'b0, 32'h1010_1010, 32'h1010_1010);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 32'h1010_1010, 32'h1010_1010);
    #2 reset = 1'b1;
    #1;
    check("midrst_o_fval", {31'd0, o_fval}, 32'd0);
    check("midrst_o_lval", {31'd0, o_lval}, 32'd0);
    check("midrst_pix", ov_pix_data, 32'd0);
    check("midrst_cnt", {8'd0, ov_noise_cnt}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_pix", ov_pix_data, 32'd0);
    i_fval = 1'b0;
    i_lval = 1'b0;
    reset = 1'b0;
    m_lfsr = SEED;
    @(posedge clk);
    #1;
    check("postrst_cnt", {8'd0, ov_noise_cnt}, 32'd0);

    // No reseed: the pixels only match if the LFSR restarted from the seed.
    fin = '{2'd2, 8'd0, 3'd6, 1'b0, 2'd2, 1'b1, 8'h80, -1};
    run_frame(fin, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
